// File: rtl/log_ram_reader_if.sv
// RAM read port and output stream bundle for log_ram_reader.
//   o_ram_en_read   : read enable toward the log RAM controller
//   o_ram_read_adrs : read address toward the log RAM controller
//   i_ram_data      : RAM read data, RD_LATENCY cycles after the address
//   o_data/o_valid  : output stream data and valid
//   i_ready         : output stream ready from the consumer
// master = the reader, slave = the RAM controller plus stream consumer.
interface log_ram_reader_if #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned AW        = 15
) ();
  logic                 o_ram_en_read;
  logic [AW-1:0]        o_ram_read_adrs;
  logic [RAM_WIDTH-1:0] i_ram_data;
  logic [RAM_WIDTH-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;

  modport master (
    output o_ram_en_read, o_ram_read_adrs, o_data, o_valid,
    input  i_ram_data, i_ready
  );

  modport slave (
    input  o_ram_en_read, o_ram_read_adrs, o_data, o_valid,
    output i_ram_data, i_ready
  );
endinterface

// File: rtl/log_ram_reader.sv
// Drains the equalizer log RAM after a capture: issues read addresses, absorbs the RAM read
// latency with an in-flight flag pipe, and buffers words in a small FIFO feeding a valid/ready
// stream. Issues are credit-limited so the FIFO can never overflow.
// Ports:
//   clk, i_reset      : clock, asynchronous active-low reset
//   i_start           : begin a readout (IDLE only), from i_start_adrs for i_num_words words
//   i_abort           : cancel a readout in progress (no done pulse)
//   bus               : RAM read port and output stream (log_ram_reader_if.master)
//   o_busy            : readout in progress (READ or DRAIN)
//   o_done            : one-cycle pulse after the last word was accepted
//   o_word_count      : words accepted in the current readout
module log_ram_reader #(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned RAM_DEPTH  = 32768,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = $clog2(RAM_DEPTH)
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [AW-1:0]   i_start_adrs,
  input  logic [AW:0]     i_num_words,
  input  logic            i_abort,
  log_ram_reader_if.master bus,
  output logic            o_busy,
  output logic            o_done,
  output logic [AW:0]     o_word_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          adr_q, adr_d;
  logic [AW:0]            remain_q, remain_d;
  logic [AW:0]            wc_q, wc_d;
  logic [RD_LATENCY-1:0]  infl_q, infl_d;
  logic [RAM_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]          infl_cnt;
  logic [AW:0]            num_clamped;
  logic                   active, issue, push, pop, flush, fifo_full;

  assign active      = (state_q == StRead) || (state_q == StDrain);
  assign flush       = i_abort && active;
  assign fifo_full   = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign num_clamped = (i_num_words > (AW+1)'(RAM_DEPTH)) ? (AW+1)'(RAM_DEPTH) : i_num_words;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      infl_cnt = infl_cnt + CW'(infl_q[i]);
    end
  end

  // Words already buffered plus words still coming out of the RAM form the credit in use.
  assign issue = (state_q == StRead) && (remain_q != '0) &&
                 (({1'b0, fifo_cnt_q} + {1'b0, infl_cnt}) < (CW+1)'(FIFO_DEPTH));
  assign push  = active && infl_q[RD_LATENCY-1];
  assign pop   = bus.o_valid && bus.i_ready;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    remain_d = remain_q;
    wc_d     = wc_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          wc_d = '0;
          if (num_clamped != '0) begin
            adr_d    = i_start_adrs;
            remain_d = num_clamped;
            state_d  = StRead;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRead: begin
        if (issue) begin
          adr_d    = (adr_q == AW'(RAM_DEPTH - 1)) ? '0 : adr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == (AW+1)'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((fifo_cnt_q == '0) && (infl_cnt == '0)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (pop) wc_d = wc_d + 1'b1;
    // Abort overrides every other transition taken this cycle.
    if (flush) begin
      state_d  = StIdle;
      remain_d = '0;
    end
  end

  always_comb begin
    infl_d = '0;
    if (!flush) begin
      infl_d[0] = issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        infl_d[i] = infl_q[i-1];
      end
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (flush) begin
      fifo_cnt_d = '0;
    end else if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 1'b1;
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      adr_q      <= '0;
      remain_q   <= '0;
      wc_q       <= '0;
      infl_q     <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      remain_q   <= remain_d;
      wc_q       <= wc_d;
      infl_q     <= infl_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: o_data is gated by o_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= bus.i_ram_data;
  end

  assign bus.o_ram_en_read   = active;
  assign bus.o_ram_read_adrs = adr_q;
  assign bus.o_valid         = (fifo_cnt_q != '0);
  assign bus.o_data          = bus.o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_busy              = active;
  assign o_done              = (state_q == StDone);
  assign o_word_count        = wc_q;

  push_overflow_a: assert property (@(posedge clk) disable iff (!i_reset) !(push && fifo_full));

endmodule

// File: tb/tb_log_ram_reader.sv
module tb_log_ram_reader;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_start_adrs = '0;
  logic [AW:0]   i_num_words = '0;
  logic          i_abort = 1'b0;
  logic          ready = 1'b1;
  bit            tog = 1'b0;

  logic          busy0, done0, busy1, done1;
  logic [AW:0]   wc0, wc1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  log_ram_reader_if #(.RAM_WIDTH(32), .AW(AW)) bus0 ();
  log_ram_reader_if #(.RAM_WIDTH(32), .AW(AW)) bus1 ();

  log_ram_reader #(.RD_LATENCY(1)) dut0 (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_start_adrs(i_start_adrs),
    .i_num_words(i_num_words), .i_abort(i_abort), .bus(bus0),
    .o_busy(busy0), .o_done(done0), .o_word_count(wc0)
  );

  log_ram_reader #(.RD_LATENCY(2)) dut1 (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_start_adrs(i_start_adrs),
    .i_num_words(i_num_words), .i_abort(i_abort), .bus(bus1),
    .o_busy(busy1), .o_done(done1), .o_word_count(wc1)
  );

  // RAM models: word at address a reads back as C0DE_0000 | a.
  logic [AW-1:0] a0_d1 = '0, a1_d1 = '0, a1_d2 = '0;
  always @(posedge clk) begin
    a0_d1 <= bus0.o_ram_read_adrs;
    a1_d1 <= bus1.o_ram_read_adrs;
    a1_d2 <= a1_d1;
  end
  assign bus0.i_ram_data = 32'hC0DE_0000 | {17'd0, a0_d1};
  assign bus1.i_ram_data = 32'hC0DE_0000 | {17'd0, a1_d2};
  assign bus0.i_ready    = ready;
  assign bus1.i_ready    = ready;

  function automatic logic [31:0] wexp(input int a);
    return 32'hC0DE_0000 | 32'(a % 32768);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitors: collect accepted words, done pulses, read-enable cycles; check stall stability.
  logic [31:0] got0[$], got1[$];
  int dc0 = 0, dc1 = 0, ec0 = 0, ec1 = 0;
  bit st0 = 1'b0, st1 = 1'b0;
  logic [31:0] pd0 = '0, pd1 = '0;

  always @(negedge clk) begin
    if (bus0.o_valid && ready) got0.push_back(bus0.o_data);
    if (done0) dc0++;
    if (bus0.o_ram_en_read) ec0++;
    if (st0 && bus0.o_valid) check("hold0", 64'(bus0.o_data), 64'(pd0));
    st0 = bus0.o_valid && !ready;
    pd0 = bus0.o_data;
  end

  always @(negedge clk) begin
    if (bus1.o_valid && ready) got1.push_back(bus1.o_data);
    if (done1) dc1++;
    if (bus1.o_ram_en_read) ec1++;
    if (st1 && bus1.o_valid) check("hold1", 64'(bus1.o_data), 64'(pd1));
    st1 = bus1.o_valid && !ready;
    pd1 = bus1.o_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) ready = ~ready;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl0"}, 64'({bus0.o_ram_en_read, bus0.o_valid, busy0, done0, wc0}), 64'd0);
    check({tag, "_bus0"}, 64'({bus0.o_ram_read_adrs, bus0.o_data}), 64'd0);
    check({tag, "_ctl1"}, 64'({bus1.o_ram_en_read, bus1.o_valid, busy1, done1, wc1}), 64'd0);
    check({tag, "_bus1"}, 64'({bus1.o_ram_read_adrs, bus1.o_data}), 64'd0);
  endtask

  // Full readout on both instances; max_cyc bounds start-to-done latency when nonzero.
  task automatic run_read(input int adrs, input int n, input int budget, input int max_cyc);
    int b0, b1, d0, d1, e0, e1, cyc;
    b0 = got0.size(); b1 = got1.size();
    d0 = dc0; d1 = dc1; e0 = ec0; e1 = ec1;
    i_start_adrs = AW'(adrs);
    i_num_words  = (AW+1)'(n);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    cyc = 1;
    while (!(dc0 > d0 && dc1 > d1) && cyc < budget) begin
      step();
      cyc++;
    end
    check("done_timeout", 64'(cyc < budget), 64'd1);
    if (max_cyc > 0) check("latency", 64'(cyc <= max_cyc), 64'd1);
    tog = 1'b0;
    ready = 1'b1;
    repeat (3) step();
    check("count0", 64'(got0.size() - b0), 64'(n));
    check("count1", 64'(got1.size() - b1), 64'(n));
    for (int i = 0; i < n && b0 + i < got0.size(); i++) check("word0", 64'(got0[b0+i]), 64'(wexp(adrs + i)));
    for (int i = 0; i < n && b1 + i < got1.size(); i++) check("word1", 64'(got1[b1+i]), 64'(wexp(adrs + i)));
    check("done_pulses0", 64'(dc0 - d0), 64'd1);
    check("done_pulses1", 64'(dc1 - d1), 64'd1);
    if (n > 0) begin
      check("wcount0", 64'(wc0), 64'(n));
      check("wcount1", 64'(wc1), 64'(n));
    end else begin
      check("en_never0", 64'(ec0 - e0), 64'd0);
      check("en_never1", 64'(ec1 - e1), 64'd0);
    end
    check("idle_after", 64'({busy0, busy1, bus0.o_ram_en_read, bus1.o_ram_en_read}), 64'd0);
  endtask

  initial begin
    int b0, b1, d0, d1, cyc;
    repeat (3) step();
    check_idle_outputs("reset");
    i_reset = 1'b1;
    repeat (2) step();

    // Back-to-back reads, latency-limited only.
    run_read(0, 8, 40, 16);
    // Stalling consumer: ready alternates every cycle.
    ready = 1'b1;
    tog = 1'b1;
    run_read(100, 16, 120, 0);
    // Address wrap at the top of the RAM.
    run_read(32766, 4, 40, 0);
    // Zero-length readout goes straight to done.
    run_read(0, 0, 6, 3);

    // Abort after exactly five words accepted by each instance.
    b0 = got0.size(); b1 = got1.size(); d0 = dc0; d1 = dc1;
    ready = 1'b0;
    i_start_adrs = AW'(500);
    i_num_words  = (AW+1)'(20);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (10) step();
    for (int k = 0; k < 5; k++) begin
      ready = 1'b1;
      step();
      ready = 1'b0;
      repeat (5) step();
    end
    check("abort_pre_busy", 64'({busy0, busy1}), 64'b11);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_valid", 64'({bus0.o_valid, bus1.o_valid}), 64'd0);
    check("abort_busy", 64'({busy0, busy1, bus0.o_ram_en_read, bus1.o_ram_en_read}), 64'd0);
    repeat (5) step();
    check("abort_nodone", 64'((dc0 - d0) + (dc1 - d1)), 64'd0);
    check("abort_cnt0", 64'(got0.size() - b0), 64'd5);
    check("abort_cnt1", 64'(got1.size() - b1), 64'd5);
    for (int i = 0; i < 5 && b0 + i < got0.size(); i++) check("abort_w0", 64'(got0[b0+i]), 64'(wexp(500 + i)));
    for (int i = 0; i < 5 && b1 + i < got1.size(); i++) check("abort_w1", 64'(got1[b1+i]), 64'(wexp(500 + i)));
    ready = 1'b1;
    run_read(2000, 3, 40, 0);

    // Second start during READ is ignored, then async reset mid-readout.
    b0 = got0.size(); b1 = got1.size(); d0 = dc0; d1 = dc1;
    ready = 1'b0;
    i_start_adrs = AW'(7000);
    i_num_words  = (AW+1)'(10);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (3) step();
    i_start_adrs = AW'(9000);
    i_num_words  = (AW+1)'(2);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    ready = 1'b1;
    cyc = 0;
    while (!(got0.size() - b0 >= 4 && got1.size() - b1 >= 4) && cyc < 30) begin
      step();
      cyc++;
    end
    check("restart_timeout", 64'(cyc < 30), 64'd1);
    for (int i = 0; i < 4 && b0 + i < got0.size(); i++) check("ign_w0", 64'(got0[b0+i]), 64'(wexp(7000 + i)));
    for (int i = 0; i < 4 && b1 + i < got1.size(); i++) check("ign_w1", 64'(got1[b1+i]), 64'(wexp(7000 + i)));
    check("ign_busy", 64'({busy0, busy1}), 64'b11);
    #2;
    i_reset = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    repeat (3) step();
    i_reset = 1'b1;
    repeat (4) step();
    check("rst_nodone", 64'((dc0 - d0) + (dc1 - d1)), 64'd0);
    check("rst_idle", 64'({busy0, busy1, bus0.o_valid, bus1.o_valid}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
